// File: rtl/i2s_input_framer.sv
// Deserialises LANES stereo I2S ADC lanes into 2*LANES scaled fixed-point samples
// and pulses start once per complete left/right audio frame.
`timescale 1ns/1ps
module i2s_input_framer #(
  parameter int unsigned LANES       = 4,
  parameter int unsigned IN_BITS     = 24,
  parameter int unsigned OUT_BITS    = 36,
  parameter int unsigned FRAC_SHIFT  = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                bclk,
  input  logic                lrclk,
  input  logic [LANES-1:0]    sdata,
  input  logic                busy,
  input  logic                err_clr,
  output logic [OUT_BITS-1:0] samples [2*LANES],
  output logic                start,
  output logic                sync_err,
  output logic [15:0]         overrun_cnt
);

  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(IN_BITS);
  localparam logic [CNT_W-1:0] WORD_END = CNT_W'(IN_BITS + 1);

  logic [SYNC_STAGES-1:0] bclk_sr;
  logic [SYNC_STAGES-1:0] lr_sr;
  logic [LANES-1:0]       sd_sr [SYNC_STAGES];
  logic                   bclk_d;
  logic                   lr_d;

  logic                   bclk_s;
  logic                   lr_s;
  logic [LANES-1:0]       sd_s;
  logic                   bclk_rise;
  logic                   lr_edge;

  logic [CNT_W-1:0]       cnt;
  logic [IN_BITS-2:0]     shreg  [LANES];
  logic [IN_BITS-1:0]     shift_nxt [LANES];
  logic [IN_BITS-1:0]     hold_l [LANES];
  logic [IN_BITS-1:0]     hold_r [LANES];
  logic                   left_done;
  logic                   locked;
  logic                   go;

  logic                   capture;
  logic                   word_done;
  logic                   short_word;
  logic                   frame;

  // Sign-extend a captured word and move it into the DSP fixed-point position.
  function automatic logic [OUT_BITS-1:0] scale(input logic [IN_BITS-1:0] w);
    logic [OUT_BITS-1:0] x;
    x = OUT_BITS'(signed'(w));
    return x << FRAC_SHIFT;
  endfunction

  // Equal-depth synchronisers keep bclk, lrclk and data phase-aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bclk_sr <= '0;
      lr_sr   <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sd_sr[i] <= '0;
      bclk_d  <= 1'b0;
      lr_d    <= 1'b0;
    end else begin
      bclk_sr[0] <= bclk;
      lr_sr[0]   <= lrclk;
      sd_sr[0]   <= sdata;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        bclk_sr[i] <= bclk_sr[i-1];
        lr_sr[i]   <= lr_sr[i-1];
        sd_sr[i]   <= sd_sr[i-1];
      end
      bclk_d <= bclk_s;
      lr_d   <= lr_s;
    end
  end

  always_comb begin
    bclk_s     = bclk_sr[SYNC_STAGES-1];
    lr_s       = lr_sr[SYNC_STAGES-1];
    sd_s       = sd_sr[SYNC_STAGES-1];
    bclk_rise  = bclk_s & ~bclk_d;
    lr_edge    = lr_s ^ lr_d;
    capture    = bclk_rise && !lr_edge && (cnt >= CNT_W'(1)) && (cnt <= LAST_BIT);
    word_done  = capture && (cnt == LAST_BIT);
    short_word = lr_edge && (cnt < WORD_END);
    frame      = word_done && lr_s && locked && left_done;
    for (int unsigned l = 0; l < LANES; l++) shift_nxt[l] = {shreg[l], sd_s[l]};
  end

  // Bit counter, shift registers and per-side holding registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      for (int unsigned l = 0; l < LANES; l++) begin
        shreg[l]  <= '0;
        hold_l[l] <= '0;
        hold_r[l] <= '0;
      end
    end else begin
      if (lr_edge) begin
        cnt <= '0;
      end else if (bclk_rise && cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
      for (int unsigned l = 0; l < LANES; l++) begin
        if (lr_edge) begin
          shreg[l] <= '0;
        end else if (capture) begin
          shreg[l] <= shift_nxt[l][IN_BITS-2:0];
        end
        if (word_done && lr_s) hold_r[l] <= shift_nxt[l];
        if (word_done && !lr_s) hold_l[l] <= shift_nxt[l];
      end
    end
  end

  // Framing state: lock on a full left word, drop it on any short word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      left_done   <= 1'b0;
      locked      <= 1'b0;
      go          <= 1'b0;
      sync_err    <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      if (short_word) begin
        left_done <= 1'b0;
        locked    <= 1'b0;
      end else if (word_done && !lr_s) begin
        left_done <= 1'b1;
        locked    <= 1'b1;
      end else if (frame) begin
        left_done <= 1'b0;
      end
      go <= frame && !busy;
      if (frame && busy && overrun_cnt != 16'hFFFF) overrun_cnt <= overrun_cnt + 16'd1;
      if (short_word) begin
        sync_err <= 1'b1;
      end else if (err_clr) begin
        sync_err <= 1'b0;
      end
    end
  end

  // Publish the accepted frame one clk after it forms.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start <= 1'b0;
      for (int unsigned c = 0; c < 2*LANES; c++) samples[c] <= '0;
    end else begin
      start <= go;
      if (go) begin
        for (int unsigned l = 0; l < LANES; l++) begin
          samples[2*l]   <= scale(hold_l[l]);
          samples[2*l+1] <= scale(hold_r[l]);
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_input_framer.sv
// Directed bench for i2s_input_framer: drives I2S frames on four lanes and checks
// sample scaling, framing, error and overrun behaviour against hand-computed values.
`timescale 1ns/1ps
module tb_i2s_input_framer;

  logic        clk = 1'b0;
  logic        reset;
  logic        bclk;
  logic        lrclk;
  logic [3:0]  sdata;
  logic        busy;
  logic        err_clr;
  logic [35:0] samples [8];
  logic        start;
  logic        sync_err;
  logic [15:0] overrun_cnt;

  logic [23:0] wl [4];
  logic [23:0] wr [4];
  int n_cmp = 0;
  int n_err = 0;
  int n_start = 0;
  int n_dbl = 0;
  logic start_q = 1'b0;

  i2s_input_framer dut (
    .clk(clk), .reset(reset), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .busy(busy), .err_clr(err_clr), .samples(samples), .start(start),
    .sync_err(sync_err), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start) n_start++;
    if (start && start_q) n_dbl++;
    start_q = start;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] model(input logic [23:0] w);
    return {{6{w[23]}}, w, 6'b0};
  endfunction

  // One I2S half-frame: slot 0 is the delay slot, slots 1..24 carry MSB first.
  task automatic drive_half(input logic lr, input int nslots, input int rel);
    for (int k = 0; k < nslots; k++) begin
      bclk = 1'b0;
      if (k == rel) reset = 1'b1;
      if (k == 0) lrclk = lr;
      for (int l = 0; l < 4; l++)
        sdata[l] = (k >= 1 && k <= 24) ? (lr ? wr[l][24-k] : wl[l][24-k]) : 1'b0;
      #40;
      bclk = 1'b1;
      #40;
    end
  endtask

  task automatic frame();
    drive_half(1'b0, 32, -1);
    drive_half(1'b1, 32, -1);
  endtask

  task automatic set_words(input logic [23:0] l, input logic [23:0] r);
    for (int i = 0; i < 4; i++) begin
      wl[i] = l;
      wr[i] = r;
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_ch%0d", tag, 2*i), 64'(samples[2*i]), 64'(model(wl[i])));
      check($sformatf("%s_ch%0d", tag, 2*i+1), 64'(samples[2*i+1]), 64'(model(wr[i])));
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    #10;
    err_clr = 1'b0;
    #10;
  endtask

  initial begin
    reset = 1'b0; bclk = 1'b0; lrclk = 1'b0; sdata = '0; busy = 1'b0; err_clr = 1'b0;
    set_words(24'h0, 24'h0);
    #23;
    for (int i = 0; i < 8; i++) check($sformatf("rst_ch%0d", i), 64'(samples[i]), 64'h0);
    check("rst_start", 64'(start), 64'h0);
    check("rst_err", 64'(sync_err), 64'h0);
    check("rst_ovr", 64'(overrun_cnt), 64'h0);
    reset = 1'b1;
    frame();

    // 1: full-scale-ish constants on every lane, four frames
    set_words(24'h400000, 24'h7FFFFF);
    n_start = 0;
    for (int f = 0; f < 4; f++) frame();
    check("t1_starts", 64'(n_start), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_even%0d", i), 64'(samples[2*i]), 64'h010000000);
      check($sformatf("t1_odd%0d", i), 64'(samples[2*i+1]), 64'h01FFFFFC0);
    end
    check("t1_err", 64'(sync_err), 64'h0);

    // 2: most negative and smallest positive on lane 0
    set_words(24'h0, 24'h0);
    wl[0] = 24'h800000;
    wr[0] = 24'h000001;
    frame();
    check("t2_ch0", 64'(samples[0]), 64'hFE0000000);
    check("t2_ch1", 64'(samples[1]), 64'h000000040);
    for (int i = 2; i < 8; i++) check($sformatf("t2_ch%0d", i), 64'(samples[i]), 64'h0);
    check("t2_starts", 64'(n_start), 64'd5);

    // 3: reset released in the middle of a right word
    reset = 1'b0;
    #80;
    for (int i = 0; i < 4; i++) begin
      wl[i] = 24'h123456 + 24'(i);
      wr[i] = 24'hABCDEF;
    end
    n_start = 0;
    drive_half(1'b1, 32, 10);
    check("t3_partial", 64'(n_start), 64'd0);
    drive_half(1'b0, 32, -1);
    check("t3_left", 64'(n_start), 64'd0);
    drive_half(1'b1, 32, -1);
    check("t3_first", 64'(n_start), 64'd1);
    frame();
    check("t3_starts", 64'(n_start), 64'd2);
    check_all("t3");

    // 4: short left word after 10 bits
    pulse_clr();
    check("t4_clr0", 64'(sync_err), 64'h0);
    set_words(24'h000100, 24'hFFFFFF);
    n_start = 0;
    drive_half(1'b0, 11, -1);
    drive_half(1'b1, 32, -1);
    check("t4_err", 64'(sync_err), 64'h1);
    check("t4_nostart", 64'(n_start), 64'd0);
    frame();
    check("t4_recover", 64'(n_start), 64'd1);
    check("t4_ch0", 64'(samples[0]), 64'h000004000);
    check("t4_ch1", 64'(samples[1]), 64'hFFFFFFFC0);
    pulse_clr();
    check("t4_clr", 64'(sync_err), 64'h0);

    // 5: busy drops three frames
    busy = 1'b1;
    set_words(24'h111111, 24'h111111);
    for (int f = 0; f < 3; f++) frame();
    check("t5_nostart", 64'(n_start), 64'd1);
    check("t5_ovr", 64'(overrun_cnt), 64'd3);
    check("t5_hold0", 64'(samples[0]), 64'h000004000);
    check("t5_hold7", 64'(samples[7]), 64'hFFFFFFFC0);
    busy = 1'b0;
    set_words(24'h222222, 24'hDDDDDD);
    frame();
    check("t5_start", 64'(n_start), 64'd2);
    check_all("t5");
    check("t5_ovr_kept", 64'(overrun_cnt), 64'd3);

    // 6: asynchronous reset mid-capture
    set_words(24'h555555, 24'h555555);
    drive_half(1'b0, 12, -1);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) check($sformatf("t6_ch%0d", i), 64'(samples[i]), 64'h0);
    check("t6_start", 64'(start), 64'h0);
    check("t6_err", 64'(sync_err), 64'h0);
    check("t6_ovr", 64'(overrun_cnt), 64'h0);

    check("no_double_start", 64'(n_dbl), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2s_input_framer.md
Name: i2s_input_framer

Overview:
- Upstream stage of DSPCore.
- Deserialises LANES stereo I2S ADC lanes, which are asynchronous to clk, into 2*LANES 36-bit fixed-point samples.
- Presents all samples in parallel on a sample array and pulses start once per audio frame, so the core begins its program.
- Full-scale input maps to ±2^29, the scaling DSPCore expects.

Parameters:
- LANES, 4, number of stereo I2S data lanes (channels = 2*LANES).
- IN_BITS, 24, significant bits per I2S word, MSB first.
- OUT_BITS, 36, DSP word width.
- FRAC_SHIFT, 6, left shift applied after sign extension (2^23 << 6 = 2^29).
- SYNC_STAGES, 2, synchroniser flops on bclk, lrclk and sdata.

Ports:
- clk  in  1  system clock; at least 8x bclk.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- bclk  in  1  I2S bit clock, asynchronous.
- lrclk  in  1  I2S word select; 0 = left, 1 = right.
- sdata  in  LANES  serial data, one bit per lane.
- busy  in  1  high while DSPCore is still processing the previous frame.
- err_clr  in  1  one-cycle pulse; clears sync_err.
- samples  out  OUT_BITS x 2*LANES (unpacked)  channel 2k = lane k left, channel 2k+1 = lane k right.
- start  out  1  one-clk pulse; a new frame is valid on samples.
- sync_err  out  1  sticky framing-error flag.
- overrun_cnt  out  16  saturating count of dropped frames.

Behaviour:
- Reset values: samples all 0, start 0, sync_err 0, overrun_cnt 0, bit counter 0, locked 0, holding registers 0.
- Synchronisation:
  - bclk, lrclk and sdata each pass through SYNC_STAGES flops (equal depth on all three).
  - bclk rise = synced bclk 0→1 seen between consecutive clk cycles.
  - lr edge = synced lrclk changed.
- Bit counter, 6 bits:
  - Cleared to 0 on lr edge.
  - Otherwise increments on each bclk rise, saturating at 63.
  - If lr edge and bclk rise occur in the same clk, the clear wins and that rise does not count.
- Data capture:
  - On a bclk rise with counter value c in 1..IN_BITS, each lane shifts in its sdata bit, MSB first.
  - c = 0 is the I2S one-bit delay slot and is ignored.
  - Bits after IN_BITS are ignored.
- Word complete: when c reaches IN_BITS+1, each lane's shift register is copied to the left holding register (synced lrclk = 0) or the right holding register (synced lrclk = 1), and a word-done flag is set for that side.
- Short word:
  - Condition: lr edge while the counter < IN_BITS+1.
  - The partial word is discarded.
  - Set sync_err.
  - Clear locked.
  - Clear the left-done flag.
- Locking: locked sets when a complete left word is latched. A right word completing while not locked does not form a frame.
- Frame formation: a right word completing while locked and left-done set forms a frame, then clears left-done.
- Frame output when busy = 0 in the cycle the frame forms:
  - Next clk: every channel becomes sign_extend(word, OUT_BITS) << FRAC_SHIFT (low bits zero).
  - start = 1 in that same cycle.
  - samples hold until the next accepted frame.
- Frame output when busy = 1: the frame is dropped, samples and start are unchanged, and overrun_cnt increments (saturating at 0xFFFF).
- start is never high for two consecutive cycles.
- Latency: one right-word LSB bclk rise, plus SYNC_STAGES+1 clk, plus 1 clk for the capture, gives start.
- err_clr clears sync_err. If err_clr coincides with a new error, the set wins.
- Reset mid-frame discards everything. The first frame after release requires a fresh full left word followed by a right word.
- Arithmetic: no rounding or saturation is needed. The range ±2^29 always fits in 36 bits.

Test Plan:
1. All lanes left 0x400000, right 0x7FFFFF, busy = 0 → one start pulse; even channels 0x010000000, odd channels 0x01FFFFFC0; exactly one start per frame over 4 frames.
2. Lane 0 left 0x800000, right 0x000001 → ch0 = 0xFE0000000, ch1 = 0x000000040; other lanes at 0 give 0x000000000.
3. Reset released mid-right-word, then 2 full frames → no start until after the first complete left-then-right pair; exactly 2 starts total, data correct.
4. lrclk toggled after 10 bits of a left word → sync_err = 1, no start for that frame, next full frame produces start; err_clr then returns sync_err to 0.
5. busy held high across 3 frames → samples and start unchanged, overrun_cnt = 3; busy low → next frame updates samples with a start pulse.
6. Assert reset (0) mid-capture → all outputs 0 immediately without a clk edge; overrun_cnt = 0, sync_err = 0.
